max_pool_2x2: RTL



---
 rtl/max_pool_2x2_pkg.sv | 13 +
 rtl/pool_line_buf.sv | 19 +
 rtl/max_pool_2x2.sv | 90 +++++++++
 3 files changed

// File: rtl/max_pool_2x2_pkg.sv
// max_pool_2x2_pkg: shared CNN-core defaults for the pooling stage and a width helper
package max_pool_2x2_pkg;
  localparam int MP_CO = 3;
  localparam int MP_AB_BW = 32;
  localparam int MP_IW = 28;
  localparam int MP_IH = 28;
  localparam int MP_POOL_OW = MP_IW / 2;
  localparam int MP_POOL_OH = MP_IH / 2;
  // At least one bit, so degenerate 2-wide maps still get a real counter/address.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-row line buffer holding even-row horizontal maxima, combinational read
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int W = 96,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: 2x2 stride-2 signed max pooling over a raster-order multi-channel stream
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int CO = MP_CO,
  parameter int AB_BW = MP_AB_BW,
  parameter int IW = MP_IW,
  parameter int IH = MP_IH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                relu_valid,
  input  logic [CO*AB_BW-1:0] x,
  output logic                pool_valid,
  output logic [CO*AB_BW-1:0] out,
  output logic                frame_done
);
  localparam int POOL_OW = IW / 2;
  localparam int POOL_OH = IH / 2;
  localparam int COL_BW = clog2_min1(IW);
  localparam int ROW_BW = clog2_min1(IH);
  localparam int LB_AW = clog2_min1(POOL_OW);
  if ((IW % 2) != 0 || (IH % 2) != 0) begin : g_bad_dims
    $error("max_pool_2x2: IW and IH must both be even");
  end
  logic [COL_BW-1:0]     col_q, col_d;
  logic [ROW_BW-1:0]     row_q, row_d;
  logic                  pool_valid_q, pool_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  emit, lb_we;
  logic [LB_AW-1:0]      lb_addr;
  logic [CO*AB_BW-1:0]   lb_wdata, lb_rdata;
  always_comb begin
    emit = relu_valid && col_q[0] && row_q[0];
    lb_we = relu_valid && col_q[0] && !row_q[0];
    lb_addr = LB_AW'(col_q >> 1);
    col_d = !relu_valid ? col_q : (col_q == COL_BW'(IW - 1)) ? '0 : col_q + 1'b1;
    row_d = !(relu_valid && col_q == COL_BW'(IW - 1)) ? row_q :
            (row_q == ROW_BW'(IH - 1)) ? '0 : row_q + 1'b1;
    pool_valid_d = emit;
    frame_done_d = emit && ((col_q >> 1) == COL_BW'(POOL_OW - 1)) &&
                   ((row_q >> 1) == ROW_BW'(POOL_OH - 1));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pool_valid_q <= pool_valid_d;
      frame_done_q <= frame_done_d;
    end
  end
  for (genvar c = 0; c < CO; c++) begin : g_ch
    logic signed [AB_BW-1:0] x_c, lb_c, hmax, vmax;
    logic signed [AB_BW-1:0] hold_q, hold_d, out_q, out_d;
    always_comb begin
      x_c = $signed(x[c*AB_BW +: AB_BW]);
      lb_c = $signed(lb_rdata[c*AB_BW +: AB_BW]);
      hmax = (hold_q > x_c) ? hold_q : x_c;
      vmax = (lb_c > hmax) ? lb_c : hmax;
      hold_d = (relu_valid && !col_q[0]) ? x_c : hold_q;
      out_d = emit ? vmax : out_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
        out_q <= '0;
      end else begin
        hold_q <= hold_d;
        out_q <= out_d;
      end
    end
    assign lb_wdata[c*AB_BW +: AB_BW] = hmax;
    assign out[c*AB_BW +: AB_BW] = out_q;
  end
  pool_line_buf #(.DEPTH(POOL_OW), .W(CO*AB_BW), .AW(LB_AW)) u_line_buf (
    .clk  (clk),
    .we   (lb_we),
    .waddr(lb_addr),
    .wdata(lb_wdata),
    .raddr(lb_addr),
    .rdata(lb_rdata)
  );
  assign pool_valid = pool_valid_q;
  assign frame_done = frame_done_q;
endmodule
